// File: rtl/clock_set_controller.sv
// Time-setting controller for a digital clock: selects run / set-hours / set-minutes / commit,
// edits a shadow copy of the time, times out idle edits and drives a blinking BCD display.
module clock_set_controller #(
    parameter int TIMEOUT_S = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [4:0]  cur_hours,
    input  logic [5:0]  cur_minutes,
    output logic        count_en,
    output logic        load,
    output logic [4:0]  load_hours,
    output logic [5:0]  load_minutes,
    output logic [1:0]  mode,
    output logic [15:0] bcd_data,
    output logic [3:0]  blank
);
    localparam int IDLE_W = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [4:0]        edit_h;
    logic [5:0]        edit_m;
    logic [IDLE_W-1:0] idle_cnt;
    logic              blink;
    logic              in_set;
    logic              any_btn;
    logic              timeout;

    function automatic logic [7:0] to_bcd(input logic [6:0] value);
        return {4'(value / 7'd10), 4'(value % 7'd10)};
    endfunction

    // A button pressed on the expiring tick keeps the edit alive.
    always_comb begin
        in_set  = (state == SET_HR) || (state == SET_MIN);
        any_btn = btn_mode || btn_inc;
        timeout = in_set && tick_1hz && !any_btn
                  && (idle_cnt == IDLE_W'(TIMEOUT_S - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        count_en   = 1'b0;
        load       = 1'b0;
        case (state)
            RUN: begin
                count_en = tick_1hz && !reset;
                if (btn_mode) begin
                    state_next = SET_HR;
                end
            end
            SET_HR: begin
                if (btn_mode) begin
                    state_next = SET_MIN;
                end else if (timeout) begin
                    state_next = RUN;
                end
            end
            SET_MIN: begin
                if (btn_mode) begin
                    state_next = COMMIT;
                end else if (timeout) begin
                    state_next = RUN;
                end
            end
            COMMIT: begin
                load       = !reset;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    assign mode = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            edit_h       <= '0;
            edit_m       <= '0;
            idle_cnt     <= '0;
            blink        <= 1'b0;
            load_hours   <= '0;
            load_minutes <= '0;
            bcd_data     <= '0;
            blank        <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (btn_mode) begin
                        edit_h <= (cur_hours > 5'd23) ? 5'd0 : cur_hours;
                        edit_m <= (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
                    end
                end
                SET_HR: begin
                    if (btn_inc && !btn_mode) begin
                        edit_h <= (edit_h == 5'd23) ? 5'd0 : edit_h + 5'd1;
                    end
                end
                SET_MIN: begin
                    if (btn_inc && !btn_mode) begin
                        edit_m <= (edit_m == 6'd59) ? 6'd0 : edit_m + 6'd1;
                    end
                    // Latch the commit values on the way into COMMIT so they are valid with load.
                    if (btn_mode) begin
                        load_hours   <= edit_h;
                        load_minutes <= edit_m;
                    end
                end
                default: ;
            endcase

            if (!in_set || any_btn) begin
                idle_cnt <= '0;
            end else if (tick_1hz) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (!in_set || btn_mode) begin
                blink <= 1'b0;
            end else if (tick_1hz) begin
                blink <= ~blink;
            end

            if (in_set) begin
                bcd_data <= {to_bcd({2'b00, edit_h}), to_bcd({1'b0, edit_m})};
            end else begin
                bcd_data <= {to_bcd({2'b00, cur_hours}), to_bcd({1'b0, cur_minutes})};
            end

            if (blink && state == SET_HR) begin
                blank <= 4'b1100;
            end else if (blink && state == SET_MIN) begin
                blank <= 4'b0011;
            end else begin
                blank <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller: directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a behavioural model of the clock setter.
module tb_clock_set_controller;
    localparam int TO = 30;

    logic        clk;
    logic        reset;
    logic        tick_1hz;
    logic        btn_mode;
    logic        btn_inc;
    logic [4:0]  cur_hours;
    logic [5:0]  cur_minutes;
    logic        count_en;
    logic        load;
    logic [4:0]  load_hours;
    logic [5:0]  load_minutes;
    logic [1:0]  mode;
    logic [15:0] bcd_data;
    logic [3:0]  blank;

    int n_checks = 0;
    int n_pass   = 0;
    bit use_model = 1'b0;

    clock_set_controller #(.TIMEOUT_S(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_1hz     (tick_1hz),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .cur_hours    (cur_hours),
        .cur_minutes  (cur_minutes),
        .count_en     (count_en),
        .load         (load),
        .load_hours   (load_hours),
        .load_minutes (load_minutes),
        .mode         (mode),
        .bcd_data     (bcd_data),
        .blank        (blank)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: mode 0..3 = run / set hours / set minutes / commit, values as plain ints.
    int          m_state = 0;
    int          m_h = 0;
    int          m_m = 0;
    int          m_idle = 0;
    bit          m_blink = 1'b0;
    int          m_lh = 0;
    int          m_lm = 0;
    logic [15:0] m_bcd = '0;
    logic [3:0]  m_blank = '0;

    function automatic logic [15:0] bcdOf(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    always @(posedge clk) begin
        int nxt;
        bit editing;
        if (reset) begin
            m_state = 0; m_h = 0; m_m = 0; m_idle = 0; m_blink = 1'b0;
            m_lh = 0; m_lm = 0; m_bcd = '0; m_blank = '0;
        end else begin
            editing = (m_state == 1) || (m_state == 2);
            m_bcd   = editing ? bcdOf(m_h, m_m) : bcdOf(int'(cur_hours), int'(cur_minutes));
            m_blank = !m_blink ? 4'h0 : (m_state == 1) ? 4'hC : (m_state == 2) ? 4'h3 : 4'h0;
            nxt = m_state;
            if (m_state == 0) begin
                if (btn_mode) begin
                    nxt = 1;
                    m_h = (cur_hours <= 23) ? int'(cur_hours) : 0;
                    m_m = (cur_minutes <= 59) ? int'(cur_minutes) : 0;
                    m_idle = 0;
                    m_blink = 1'b0;
                end
            end else if (editing) begin
                if (btn_mode) begin
                    nxt = m_state + 1;
                    if (m_state == 2) begin
                        m_lh = m_h;
                        m_lm = m_m;
                    end
                end else if (btn_inc) begin
                    if (m_state == 1) m_h = (m_h + 1) % 24;
                    else              m_m = (m_m + 1) % 60;
                end
                if (btn_mode || btn_inc) begin
                    m_idle = 0;
                end else if (tick_1hz) begin
                    m_idle++;
                    if (m_idle == TO) nxt = 0;
                end
                if (btn_mode)      m_blink = 1'b0;
                else if (tick_1hz) m_blink = !m_blink;
                if (nxt != 1 && nxt != 2) begin
                    m_idle = 0;
                    m_blink = 1'b0;
                end
            end else begin
                nxt = 0;
            end
            m_state = nxt;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit t, input bit bm, input bit bi,
                                 input logic [4:0] ch, input logic [5:0] cm);
        @(negedge clk);
        reset = rst; tick_1hz = t; btn_mode = bm; btn_inc = bi;
        cur_hours = ch; cur_minutes = cm;
        #1;
        if (use_model) begin
            checkOutput("model_count_en", 32'(count_en), 32'(!rst && m_state == 0 && t));
            checkOutput("model_load", 32'(load), 32'(!rst && m_state == 3));
            checkOutput("model_mode", 32'(mode), 32'(m_state));
            checkOutput("model_load_hours", 32'(load_hours), 32'(m_lh));
            checkOutput("model_load_minutes", 32'(load_minutes), 32'(m_lm));
            checkOutput("model_bcd_data", 32'(bcd_data), 32'(m_bcd));
            checkOutput("model_blank", 32'(blank), 32'(m_blank));
        end
    endtask

    typedef struct {
        bit          tick;
        bit          bm;
        bit          bi;
        logic [4:0]  ch;
        logic [5:0]  cm;
        logic [1:0]  e_mode;
        bit          e_cnt;
        bit          e_load;
        logic [4:0]  e_lh;
        logic [5:0]  e_lm;
        logic [15:0] e_bcd;
        logic [3:0]  e_blank;
    } vec_t;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        // Run with ticks, then 22:58 -> set 00:01, then mode+inc together, blink in minutes, commit.
        vecs.push_back('{1,0,0, 5'd22,6'd58, 2'd0,1,0, 5'd0,6'd0,  16'h2258,4'h0});
        vecs.push_back('{0,0,0, 5'd22,6'd58, 2'd0,0,0, 5'd0,6'd0,  16'h2258,4'h0});
        vecs.push_back('{1,0,0, 5'd22,6'd58, 2'd0,1,0, 5'd0,6'd0,  16'h2258,4'h0});
        vecs.push_back('{1,0,0, 5'd22,6'd58, 2'd0,1,0, 5'd0,6'd0,  16'h2258,4'h0});
        vecs.push_back('{0,1,0, 5'd22,6'd58, 2'd0,0,0, 5'd0,6'd0,  16'h2258,4'h0});
        vecs.push_back('{0,0,1, 5'd22,6'd58, 2'd1,0,0, 5'd0,6'd0,  16'h2258,4'h0});
        vecs.push_back('{0,0,1, 5'd22,6'd58, 2'd1,0,0, 5'd0,6'd0,  16'h2258,4'h0});
        vecs.push_back('{0,1,0, 5'd22,6'd58, 2'd1,0,0, 5'd0,6'd0,  16'h2358,4'h0});
        vecs.push_back('{0,0,1, 5'd22,6'd58, 2'd2,0,0, 5'd0,6'd0,  16'h0058,4'h0});
        vecs.push_back('{0,0,1, 5'd22,6'd58, 2'd2,0,0, 5'd0,6'd0,  16'h0058,4'h0});
        vecs.push_back('{0,0,1, 5'd22,6'd58, 2'd2,0,0, 5'd0,6'd0,  16'h0059,4'h0});
        vecs.push_back('{0,1,0, 5'd22,6'd58, 2'd2,0,0, 5'd0,6'd0,  16'h0000,4'h0});
        vecs.push_back('{1,1,1, 5'd22,6'd58, 2'd3,0,1, 5'd0,6'd1,  16'h0001,4'h0});
        vecs.push_back('{0,0,0, 5'd22,6'd58, 2'd0,0,0, 5'd0,6'd1,  16'h2258,4'h0});
        vecs.push_back('{0,1,0, 5'd22,6'd58, 2'd0,0,0, 5'd0,6'd1,  16'h2258,4'h0});
        vecs.push_back('{0,1,1, 5'd22,6'd58, 2'd1,0,0, 5'd0,6'd1,  16'h2258,4'h0});
        vecs.push_back('{0,0,0, 5'd22,6'd58, 2'd2,0,0, 5'd0,6'd1,  16'h2258,4'h0});
        vecs.push_back('{0,0,0, 5'd22,6'd58, 2'd2,0,0, 5'd0,6'd1,  16'h2258,4'h0});
        vecs.push_back('{1,0,0, 5'd22,6'd58, 2'd2,0,0, 5'd0,6'd1,  16'h2258,4'h0});
        vecs.push_back('{0,0,0, 5'd22,6'd58, 2'd2,0,0, 5'd0,6'd1,  16'h2258,4'h0});
        vecs.push_back('{1,0,0, 5'd22,6'd58, 2'd2,0,0, 5'd0,6'd1,  16'h2258,4'h3});
        vecs.push_back('{0,0,0, 5'd22,6'd58, 2'd2,0,0, 5'd0,6'd1,  16'h2258,4'h3});
        vecs.push_back('{0,0,0, 5'd22,6'd58, 2'd2,0,0, 5'd0,6'd1,  16'h2258,4'h0});
        vecs.push_back('{0,1,0, 5'd22,6'd58, 2'd2,0,0, 5'd0,6'd1,  16'h2258,4'h0});
        vecs.push_back('{0,0,0, 5'd22,6'd58, 2'd3,0,1, 5'd22,6'd58,16'h2258,4'h0});
        vecs.push_back('{0,0,0, 5'd22,6'd58, 2'd0,0,0, 5'd22,6'd58,16'h2258,4'h0});

        reset = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        cur_hours = 5'd22; cur_minutes = 6'd58;

        applyStimulus(1, 0, 0, 0, 5'd22, 6'd58);
        applyStimulus(1, 0, 0, 0, 5'd22, 6'd58);
        use_model = 1'b1;
        applyStimulus(0, 0, 0, 0, 5'd22, 6'd58);
        checkOutput("reset_mode", 32'(mode), 32'd0);
        checkOutput("reset_load", 32'(load), 32'd0);
        checkOutput("reset_load_hm", 32'({load_hours, load_minutes}), 32'd0);
        checkOutput("reset_bcd", 32'(bcd_data), 32'd0);
        checkOutput("reset_blank", 32'(blank), 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].tick, vecs[i].bm, vecs[i].bi, vecs[i].ch, vecs[i].cm);
            checkOutput($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].e_mode));
            checkOutput($sformatf("vec%0d_count_en", i), 32'(count_en), 32'(vecs[i].e_cnt));
            checkOutput($sformatf("vec%0d_load", i), 32'(load), 32'(vecs[i].e_load));
            checkOutput($sformatf("vec%0d_load_hours", i), 32'(load_hours), 32'(vecs[i].e_lh));
            checkOutput($sformatf("vec%0d_load_minutes", i), 32'(load_minutes), 32'(vecs[i].e_lm));
            checkOutput($sformatf("vec%0d_bcd", i), 32'(bcd_data), 32'(vecs[i].e_bcd));
            checkOutput($sformatf("vec%0d_blank", i), 32'(blank), 32'(vecs[i].e_blank));
        end

        // Idle timeout from 12:34 edited to 17:34: abandoned after TO ticks, no load.
        applyStimulus(0, 0, 1, 0, 5'd12, 6'd34);
        repeat (5) applyStimulus(0, 0, 0, 1, 5'd12, 6'd34);
        for (int k = 1; k <= TO; k++) begin
            applyStimulus(0, 1, 0, 0, 5'd12, 6'd34);
            if (k == 1) checkOutput("set_tick_count_en", 32'(count_en), 32'd0);
            applyStimulus(0, 0, 0, 0, 5'd12, 6'd34);
            if (k == TO - 1) checkOutput("pre_timeout_mode", 32'(mode), 32'd1);
            if (k == TO) begin
                checkOutput("timeout_mode", 32'(mode), 32'd0);
                checkOutput("timeout_load", 32'(load), 32'd0);
            end
        end
        applyStimulus(0, 0, 0, 0, 5'd12, 6'd34);
        checkOutput("timeout_bcd", 32'(bcd_data), 32'h1234);

        // Button on the expiring tick wins and restarts the idle count.
        applyStimulus(0, 0, 1, 0, 5'd12, 6'd34);
        for (int k = 1; k < TO; k++) begin
            applyStimulus(0, 1, 0, 0, 5'd12, 6'd34);
            applyStimulus(0, 0, 0, 0, 5'd12, 6'd34);
        end
        applyStimulus(0, 1, 0, 1, 5'd12, 6'd34);
        applyStimulus(0, 0, 0, 0, 5'd12, 6'd34);
        checkOutput("btn_beats_timeout_mode", 32'(mode), 32'd1);
        for (int k = 1; k < TO; k++) begin
            applyStimulus(0, 1, 0, 0, 5'd12, 6'd34);
            applyStimulus(0, 0, 0, 0, 5'd12, 6'd34);
        end
        checkOutput("idle_restarted_mode", 32'(mode), 32'd1);

        // Reset in the middle of editing minutes = 45 aborts without a load.
        applyStimulus(0, 0, 1, 0, 5'd12, 6'd34);
        repeat (11) applyStimulus(0, 0, 0, 1, 5'd12, 6'd34);
        applyStimulus(0, 1, 0, 0, 5'd12, 6'd34);
        applyStimulus(0, 0, 0, 0, 5'd12, 6'd34);
        applyStimulus(0, 0, 0, 0, 5'd12, 6'd34);
        checkOutput("edit_bcd_1345", 32'(bcd_data), 32'h1345);
        checkOutput("edit_blank_min", 32'(blank), 32'h3);
        applyStimulus(1, 1, 1, 1, 5'd12, 6'd34);
        applyStimulus(0, 0, 0, 0, 5'd12, 6'd34);
        checkOutput("abort_mode", 32'(mode), 32'd0);
        checkOutput("abort_load", 32'(load), 32'd0);
        checkOutput("abort_bcd", 32'(bcd_data), 32'd0);
        checkOutput("abort_blank", 32'(blank), 32'd0);
        checkOutput("abort_load_hm", 32'({load_hours, load_minutes}), 32'd0);

        // Randomized traffic alternating busy and quiet segments so timeouts also occur.
        for (int seg = 0; seg < 20; seg++) begin
            int btn_div;
            btn_div = (seg % 2 == 1) ? 200 : 6;
            for (int c = 0; c < 150; c++) begin
                applyStimulus($urandom_range(299) == 0,
                              $urandom_range(1) == 1,
                              (c == 0) || ($urandom_range(btn_div - 1) == 0),
                              $urandom_range(btn_div - 1) == 0,
                              5'($urandom_range(31)),
                              6'($urandom_range(63)));
            end
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
